// File: rtl/e203_ifu_flush_rsp_pkg.sv
// Shared IFU definitions: fetch-sequencer state encoding and PC step.
package e203_ifu_flush_rsp_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,  // nothing outstanding
    ST_WAIT  = 2'd1,  // one fetch outstanding, its response is wanted
    ST_DRAIN = 2'd2,  // one fetch outstanding, its response is stale
    ST_HALT  = 2'd3
  } ifu_state_e;

  localparam int unsigned PC_INCR = 4;

endpackage

// File: rtl/e203_ifu_obuf.sv
// Single-entry instruction buffer toward decode; a load is visible next cycle.
// Holds its entry until o_vld & o_rdy; flush clears it and beats a simultaneous load.
module e203_ifu_obuf #(
  parameter int PC_SIZE = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               i_vld,
  input  logic [PC_SIZE-1:0] i_pc,
  input  logic [31:0]        i_instr,
  input  logic               i_err,
  output logic               o_vld,
  input  logic               o_rdy,
  output logic [PC_SIZE-1:0] o_pc,
  output logic [31:0]        o_instr,
  output logic               o_err
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_vld   <= 1'b0;
      o_pc    <= '0;
      o_instr <= '0;
      o_err   <= 1'b0;
    end else if (flush) begin
      o_vld <= 1'b0;
    end else if (i_vld) begin
      o_vld   <= 1'b1;
      o_pc    <= i_pc;
      o_instr <= i_instr;
      o_err   <= i_err;
    end else if (o_vld && o_rdy) begin
      o_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/e203_ifu_flush_rsp.sv
// IFU fetch sequencer: one outstanding fetch, flush redirect, stale-response drain, WFI halt.
// Request is combinational from state; a response reaches ifu_o one cycle later; decode stalls hold the next request.
module e203_ifu_flush_rsp
  import e203_ifu_flush_rsp_pkg::*;
#(
  parameter int                PC_SIZE  = 32,
  parameter logic [PC_SIZE-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pipe_flush_req,
  input  logic [PC_SIZE-1:0] pipe_flush_add_op1,
  input  logic [PC_SIZE-1:0] pipe_flush_add_op2,
  output logic               pipe_flush_ack,
  input  logic               ifu_halt_req,
  output logic               ifu_halt_ack,
  output logic               ifu_req_valid,
  input  logic               ifu_req_ready,
  output logic [PC_SIZE-1:0] ifu_req_pc,
  input  logic               ifu_rsp_valid,
  output logic               ifu_rsp_ready,
  input  logic [31:0]        ifu_rsp_instr,
  input  logic               ifu_rsp_err,
  output logic               ifu_o_valid,
  input  logic               ifu_o_ready,
  output logic [PC_SIZE-1:0] ifu_o_pc,
  output logic [31:0]        ifu_o_instr,
  output logic               ifu_o_buserr
);

  localparam logic [PC_SIZE-1:0] PC_STEP = PC_SIZE'(PC_INCR);

  ifu_state_e         state, state_nxt;
  logic [PC_SIZE-1:0] pc;
  logic [PC_SIZE-1:0] fetch_pc;
  logic [PC_SIZE-1:0] flush_tgt;
  logic               flush;
  logic               issue;
  logic               buf_load;
  logic               buf_vld;

  assign pipe_flush_ack = ~rst;
  assign flush          = pipe_flush_req & pipe_flush_ack;
  assign flush_tgt      = pipe_flush_add_op1 + pipe_flush_add_op2;

  assign ifu_req_valid = ~rst && (state == ST_RUN) && !flush && !ifu_halt_req
                         && (!buf_vld || ifu_o_ready);
  assign ifu_req_pc    = pc;
  assign issue         = ifu_req_valid & ifu_req_ready;

  assign ifu_rsp_ready = 1'b1;
  assign buf_load      = (state == ST_WAIT) & ifu_rsp_valid;
  assign ifu_halt_ack  = (state == ST_HALT);
  assign ifu_o_valid   = buf_vld;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (flush)                          state_nxt = ST_RUN;
        else if (issue)                     state_nxt = ST_WAIT;
        else if (ifu_halt_req && !buf_vld)  state_nxt = ST_HALT;
      end
      // A response landing with the flush retires the fetch, so nothing is left to drain.
      ST_WAIT: begin
        if (ifu_rsp_valid)                  state_nxt = ST_RUN;
        else if (flush)                     state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (ifu_rsp_valid)                  state_nxt = ST_RUN;
      end
      ST_HALT: begin
        if (flush || !ifu_halt_req)         state_nxt = ST_RUN;
      end
      default:                              state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_RUN;
      pc       <= RESET_PC;
      fetch_pc <= RESET_PC;
    end else begin
      state <= state_nxt;
      if (flush) begin
        pc <= flush_tgt;
      end else if (issue) begin
        pc       <= pc + PC_STEP;
        fetch_pc <= pc;
      end
    end
  end

  e203_ifu_obuf #(
    .PC_SIZE (PC_SIZE)
  ) u_obuf (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .i_vld   (buf_load),
    .i_pc    (fetch_pc),
    .i_instr (ifu_rsp_instr),
    .i_err   (ifu_rsp_err),
    .o_vld   (buf_vld),
    .o_rdy   (ifu_o_ready),
    .o_pc    (ifu_o_pc),
    .o_instr (ifu_o_instr),
    .o_err   (ifu_o_buserr)
  );

endmodule

// File: tb/tb_e203_ifu_flush_rsp.sv
// Bench for e203_ifu_flush_rsp: directed scenarios then random traffic against a transaction-level model.
module tb_e203_ifu_flush_rsp;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_flush_req;
  logic [31:0] pipe_flush_add_op1, pipe_flush_add_op2;
  logic        pipe_flush_ack;
  logic        ifu_halt_req, ifu_halt_ack;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_req_pc;
  logic        ifu_rsp_valid, ifu_rsp_ready;
  logic [31:0] ifu_rsp_instr;
  logic        ifu_rsp_err;
  logic        ifu_o_valid, ifu_o_ready;
  logic [31:0] ifu_o_pc, ifu_o_instr;
  logic        ifu_o_buserr;

  always #5 clk = ~clk;

  e203_ifu_flush_rsp #(.PC_SIZE(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .pipe_flush_req(pipe_flush_req), .pipe_flush_add_op1(pipe_flush_add_op1),
    .pipe_flush_add_op2(pipe_flush_add_op2), .pipe_flush_ack(pipe_flush_ack),
    .ifu_halt_req(ifu_halt_req), .ifu_halt_ack(ifu_halt_ack),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_pc(ifu_req_pc),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
    .ifu_rsp_instr(ifu_rsp_instr), .ifu_rsp_err(ifu_rsp_err),
    .ifu_o_valid(ifu_o_valid), .ifu_o_ready(ifu_o_ready), .ifu_o_pc(ifu_o_pc),
    .ifu_o_instr(ifu_o_instr), .ifu_o_buserr(ifu_o_buserr)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level view: is a fetch in flight, is it wanted, what PC comes next,
  // what decode currently holds, and whether commit has been told the IFU is halted.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } ent_t;

  ent_t        bq[$];
  bit          m_out, m_stale, m_halt;
  logic [31:0] m_pc, m_fpc;

  task automatic model_reset();
    m_out = 0; m_stale = 0; m_halt = 0;
    m_pc = RESET_PC; m_fpc = RESET_PC;
    bq.delete();
  endtask

  // One clock: drive inputs, check at negedge, advance the model, return at posedge+1.
  task automatic step(input logic fl, input logic [31:0] a, input logic [31:0] b,
                      input logic hr, input logic ordy, input logic qrdy,
                      input logic rgo, input logic [31:0] ins);
    bit   rv, iss, rsp, hn;
    ent_t e;
    pipe_flush_req     = fl;
    pipe_flush_add_op1 = a;
    pipe_flush_add_op2 = b;
    ifu_halt_req       = hr;
    ifu_o_ready        = ordy;
    ifu_req_ready      = qrdy;
    ifu_rsp_valid      = rgo & m_out;
    ifu_rsp_instr      = ins;
    ifu_rsp_err        = 1'($urandom_range(0, 1));
    @(negedge clk);
    rv = !m_out && !m_halt && !fl && !hr && (bq.size() == 0 || ordy);
    chk("flush_ack", 64'(pipe_flush_ack), 64'd1);
    chk("rsp_ready", 64'(ifu_rsp_ready), 64'd1);
    chk("req_valid", 64'(ifu_req_valid), 64'(rv));
    if (rv) chk("req_pc", 64'(ifu_req_pc), 64'(m_pc));
    chk("o_valid", 64'(ifu_o_valid), 64'(bq.size() != 0));
    if (bq.size() != 0) begin
      chk("o_pc", 64'(ifu_o_pc), 64'(bq[0].pc));
      chk("o_instr", 64'(ifu_o_instr), 64'(bq[0].instr));
      chk("o_buserr", 64'(ifu_o_buserr), 64'(bq[0].err));
    end
    chk("halt_ack", 64'(ifu_halt_ack), 64'(m_halt));
    iss = rv && qrdy;
    rsp = ifu_rsp_valid;
    hn  = m_halt ? !(fl || !hr) : (!m_out && !fl && hr && bq.size() == 0);
    if (bq.size() != 0 && ordy) void'(bq.pop_front());
    if (rsp) begin
      if (!m_stale && !fl) begin
        e.pc = m_fpc; e.instr = ins; e.err = ifu_rsp_err;
        bq.push_back(e);
      end
      m_out = 0; m_stale = 0;
    end
    if (fl) begin
      bq.delete();
      if (m_out) m_stale = 1;
      m_pc = a + b;
    end
    if (iss) begin
      m_out = 1; m_stale = 0; m_fpc = m_pc; m_pc = m_pc + 32'd4;
    end
    m_halt = hn;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] i0, i1;
  bit          hold_hr;

  initial begin
    rst = 1'b1;
    pipe_flush_req = 0; pipe_flush_add_op1 = 0; pipe_flush_add_op2 = 0;
    ifu_halt_req = 0; ifu_req_ready = 0; ifu_rsp_valid = 0; ifu_rsp_instr = 0;
    ifu_rsp_err = 0; ifu_o_ready = 0;
    #1;
    chk("rst_req_valid", 64'(ifu_req_valid), 64'd0);
    chk("rst_o_valid", 64'(ifu_o_valid), 64'd0);
    chk("rst_halt_ack", 64'(ifu_halt_ack), 64'd0);
    chk("rst_flush_ack", 64'(pipe_flush_ack), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Back-to-back fetches reach decode with their own PC and instruction.
    i0 = $urandom; i1 = $urandom;
    step(0, 0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, i0);
    chk("seq_o_pc0", 64'(ifu_o_pc), 64'h8000_0000);
    chk("seq_o_instr0", 64'(ifu_o_instr), 64'(i0));
    step(0, 0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, i1);
    chk("seq_o_pc1", 64'(ifu_o_pc), 64'h8000_0004);
    chk("seq_o_instr1", 64'(ifu_o_instr), 64'(i1));

    // Flush in RUN with a full buffer: buffer dropped, redirect next cycle.
    step(1, 32'h8000_0100, 32'h20, 0, 0, 1, 0, 0);
    chk("run_flush_obuf", 64'(ifu_o_valid), 64'd0);
    chk("run_flush_pc", 64'(ifu_req_pc), 64'h8000_0120);
    step(0, 0, 0, 0, 0, 1, 0, 0);

    // Flush while waiting: the stale response never reaches decode.
    step(1, 32'h400, 32'h0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, 32'hDEAD_BEEF);
    chk("drain_obuf", 64'(ifu_o_valid), 64'd0);
    chk("drain_pc", 64'(ifu_req_pc), 64'h400);
    step(0, 0, 0, 0, 0, 1, 0, 0);

    // Two flushes while draining: newest target wins.
    step(1, 32'h200, 32'h0, 0, 0, 1, 0, 0);
    step(1, 32'h100, 32'h200, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, $urandom);
    chk("dbl_flush_pc", 64'(ifu_req_pc), 64'h300);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1, $urandom);
    chk("dbl_flush_o_pc", 64'(ifu_o_pc), 64'h300);

    // Halt waits for decode to drain the buffer, then acks two cycles after ready.
    step(0, 0, 0, 1, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 1, 0, 0);
    chk("halt_full_noack", 64'(ifu_halt_ack), 64'd0);
    step(0, 0, 0, 1, 1, 1, 0, 0);
    chk("halt_ack_early", 64'(ifu_halt_ack), 64'd0);
    step(0, 0, 0, 1, 1, 1, 0, 0);
    chk("halt_ack", 64'(ifu_halt_ack), 64'd1);
    step(0, 0, 0, 0, 1, 1, 0, 0);
    chk("halt_release", 64'(ifu_halt_ack), 64'd0);
    step(1, 32'h500, 32'h0, 1, 1, 1, 0, 0);
    chk("flush_beats_halt", 64'(ifu_halt_ack), 64'd0);
    chk("flush_beats_halt_pc", 64'(ifu_req_pc), 64'h500);

    // Target wraps modulo 2^32; reset mid-fetch clears everything at once.
    step(1, 32'hFFFF_FFF0, 32'h20, 0, 1, 1, 0, 0);
    chk("wrap_pc", 64'(ifu_req_pc), 64'h10);
    step(0, 0, 0, 0, 1, 1, 0, 0);
    pipe_flush_req = 0; ifu_halt_req = 0; ifu_req_ready = 1; ifu_rsp_valid = 0;
    rst = 1'b1;
    #1;
    chk("mid_rst_req_valid", 64'(ifu_req_valid), 64'd0);
    chk("mid_rst_o_valid", 64'(ifu_o_valid), 64'd0);
    chk("mid_rst_halt_ack", 64'(ifu_halt_ack), 64'd0);
    chk("mid_rst_flush_ack", 64'(pipe_flush_ack), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    chk("restart_valid", 64'(ifu_req_valid), 64'd1);
    chk("restart_pc", 64'(ifu_req_pc), 64'(RESET_PC));

    hold_hr = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) == 0) hold_hr = !hold_hr;
      step($urandom_range(0, 9) == 0, $urandom, $urandom, hold_hr,
           $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
